// File: rtl/pwm_core.sv
// PWM generator fed by the AXI-Lite register file. Config is captured into shadow
// registers only at a period boundary, so a running waveform never glitches.
module pwm_core #(
   parameter int CNT_WIDTH          = 16,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          cfg_enable,
   input  logic                          cfg_polarity,
   input  logic [CNT_WIDTH-1:0]          cfg_period,
   input  logic [CNT_WIDTH-1:0]          cfg_duty,
   input  logic                          cfg_update,
   output logic                          pwm_out,
   output logic                          period_tick,
   output logic                          busy,
   output logic                          update_pending,
   output logic [C_S_AXI_DATA_WIDTH-1:0] cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] act_period;
   logic [CNT_WIDTH-1:0] act_duty;
   logic                 act_pol;

   logic [CNT_WIDTH-1:0] eff_p;
   logic                 term;
   logic                 load;
   logic [CNT_WIDTH-1:0] cnt_next;

   assign eff_p    = (cfg_period == '0) ? CNT_WIDTH'(1) : cfg_period;
   assign term     = (state != IDLE) && (cnt == act_period - CNT_WIDTH'(1));
   // A pending or same-cycle update is consumed at the boundary, using live cfg values.
   assign load     = ((state == IDLE) && cfg_enable) ||
                     (term && (update_pending || cfg_update));
   assign cnt_next = term ? '0 : cnt + CNT_WIDTH'(1);
   assign busy     = (state != IDLE);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state          <= IDLE;
         cnt            <= '0;
         act_period     <= CNT_WIDTH'(1);
         act_duty       <= '0;
         act_pol        <= 1'b0;
         pwm_out        <= 1'b0;
         period_tick    <= 1'b0;
         update_pending <= 1'b0;
         cycle_count    <= '0;
      end else begin
         if (load) begin
            act_period     <= eff_p;
            act_duty       <= cfg_duty;
            act_pol        <= cfg_polarity;
            update_pending <= 1'b0;
         end else if (cfg_update) begin
            update_pending <= 1'b1;
         end

         period_tick <= term;
         if (period_tick)
            cycle_count <= cycle_count + C_S_AXI_DATA_WIDTH'(1);

         // Idle output follows the live polarity register, not the shadow.
         if (state == IDLE)
            pwm_out <= cfg_polarity;
         else
            pwm_out <= (cnt < act_duty) ^ act_pol;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (cfg_enable)
                  state <= RUN;
            end
            RUN: begin
               cnt <= cnt_next;
               if (!cfg_enable)
                  state <= DRAIN;
            end
            DRAIN: begin
               cnt <= cnt_next;
               if (cfg_enable)
                  state <= RUN;
               else if (term)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
